// File: rtl/mouse_pkg.sv
// Shared PS/2 mouse definitions: master state encoding, command/response bytes,
// receiver error codes and small state-classification helpers.
package mouse_pkg;

    typedef enum logic [3:0] {
        S_INIT          = 4'd0,
        S_SEND_RST      = 4'd1,
        S_WAIT_SENT_RST = 4'd2,
        S_ACK_RST       = 4'd3,
        S_SELFTEST      = 4'd4,
        S_ID            = 4'd5,
        S_SEND_EN       = 4'd6,
        S_WAIT_SENT_EN  = 4'd7,
        S_ACK_EN        = 4'd8,
        S_STATUS        = 4'd9,
        S_DX            = 4'd10,
        S_DY            = 4'd11,
        S_INTR          = 4'd12
    } state_t;

    localparam logic [7:0] CMD_RESET     = 8'hFF;
    localparam logic [7:0] CMD_EN_STREAM = 8'hF4;

    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_SELFTEST = 8'hAA;
    localparam logic [7:0] RSP_ID       = 8'h00;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_PARITY = 2'b01;
    localparam logic [1:0] ERR_FRAME  = 2'b10;

    // Bit 3 of a movement status byte is always set; used to find packet boundaries.
    localparam int STATUS_SYNC_BIT = 3;

    function automatic logic is_read_state(input state_t s);
        return s inside {S_ACK_RST, S_SELFTEST, S_ID, S_ACK_EN, S_STATUS, S_DX, S_DY};
    endfunction

    function automatic logic [7:0] expected_rsp(input state_t s);
        case (s)
            S_ACK_RST, S_ACK_EN: return RSP_ACK;
            S_SELFTEST:          return RSP_SELFTEST;
            default:             return RSP_ID;
        endcase
    endfunction

endpackage

// File: rtl/mouse_timeout_ctr.sv
// Saturating cycle counter with synchronous clear; expired is high once the
// count has reached the supplied limit and stays high until cleared.
module mouse_timeout_ctr #(
    parameter int WIDTH = 26
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clear,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count < limit) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count >= limit);

endmodule

// File: rtl/mouse_master_sm.sv
// PS/2 mouse master: power-up handshake (reset, self-test, ID, enable streaming)
// followed by 3-byte movement packet assembly with a one-cycle interrupt per packet.
module mouse_master_sm
    import mouse_pkg::*;
#(
    parameter int INIT_WAIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES   = 50_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic       SEND_INTERRUPT,
    output logic [3:0] MASTER_STATE
);

    localparam int MAX_LIMIT = (INIT_WAIT_CYCLES > TIMEOUT_CYCLES) ? INIT_WAIT_CYCLES
                                                                    : TIMEOUT_CYCLES;
    localparam int CNT_W     = $clog2(MAX_LIMIT + 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] limit;
    logic             expired;
    logic             state_change;
    logic             rx_ok;
    logic             rsp_ok;

    logic             send_byte_d;
    logic [7:0]       byte_to_send_d;
    logic             read_enable_d;
    logic             send_interrupt_d;
    logic             capture_status;
    logic             capture_dx;
    logic             publish_packet;

    logic [7:0]       status_hold;
    logic [7:0]       dx_hold;

    // One counter serves both the power-up wait and the per-state timeout.
    assign limit        = (state == S_INIT) ? CNT_W'(INIT_WAIT_CYCLES) : CNT_W'(TIMEOUT_CYCLES);
    assign state_change = (next_state != state);
    assign rx_ok        = BYTE_READY && (BYTE_ERROR_CODE == ERR_NONE);
    assign rsp_ok       = rx_ok && (BYTE_READ == expected_rsp(state));

    mouse_timeout_ctr #(
        .WIDTH (CNT_W)
    ) u_timeout_ctr (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (state_change),
        .limit   (limit),
        .expired (expired)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= S_INIT;
        end else begin
            state <= next_state;
        end
    end

    // BYTE_READY is tested ahead of expired so a byte arriving on the last cycle still counts.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        next_state = state;
        case (state)
            S_INIT: begin
                if (expired) next_state = S_SEND_RST;
            end
            S_SEND_RST: next_state = S_WAIT_SENT_RST;
            S_WAIT_SENT_RST: begin
                if (BYTE_SENT)    next_state = S_ACK_RST;
                else if (expired) next_state = S_INIT;
            end
            S_ACK_RST: begin
                if (BYTE_READY)   next_state = rsp_ok ? S_SELFTEST : S_INIT;
                else if (expired) next_state = S_INIT;
            end
            S_SELFTEST: begin
                if (BYTE_READY)   next_state = rsp_ok ? S_ID : S_INIT;
                else if (expired) next_state = S_INIT;
            end
            S_ID: begin
                if (BYTE_READY)   next_state = rsp_ok ? S_SEND_EN : S_INIT;
                else if (expired) next_state = S_INIT;
            end
            S_SEND_EN: next_state = S_WAIT_SENT_EN;
            S_WAIT_SENT_EN: begin
                if (BYTE_SENT)    next_state = S_ACK_EN;
                else if (expired) next_state = S_INIT;
            end
            S_ACK_EN: begin
                if (BYTE_READY)   next_state = rsp_ok ? S_STATUS : S_INIT;
                else if (expired) next_state = S_INIT;
            end
            S_STATUS: begin
                if (rx_ok && BYTE_READ[STATUS_SYNC_BIT]) next_state = S_DX;
            end
            S_DX: begin
                if (BYTE_READY)   next_state = rx_ok ? S_DY : S_STATUS;
                else if (expired) next_state = S_STATUS;
            end
            S_DY: begin
                if (BYTE_READY)   next_state = rx_ok ? S_INTR : S_STATUS;
                else if (expired) next_state = S_STATUS;
            end
            S_INTR:  next_state = S_STATUS;
            default: next_state = S_INIT;
        endcase
    end

    // Outputs are decoded from next_state and registered, so they line up with MASTER_STATE.
    always_comb begin
        send_byte_d      = (next_state == S_SEND_RST) || (next_state == S_SEND_EN);
        byte_to_send_d   = BYTE_TO_SEND;
        read_enable_d    = is_read_state(next_state);
        send_interrupt_d = (next_state == S_INTR);
        capture_status   = (state == S_STATUS) && (next_state == S_DX);
        capture_dx       = (state == S_DX)     && (next_state == S_DY);
        publish_packet   = (state == S_DY)     && (next_state == S_INTR);
        if (next_state == S_SEND_RST)     byte_to_send_d = CMD_RESET;
        else if (next_state == S_SEND_EN) byte_to_send_d = CMD_EN_STREAM;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            SEND_BYTE      <= 1'b0;
            BYTE_TO_SEND   <= 8'h00;
            READ_ENABLE    <= 1'b0;
            SEND_INTERRUPT <= 1'b0;
            MOUSE_STATUS   <= 8'h00;
            MOUSE_DX       <= 8'h00;
            MOUSE_DY       <= 8'h00;
            status_hold    <= 8'h00;
            dx_hold        <= 8'h00;
        end else begin
            SEND_BYTE      <= send_byte_d;
            BYTE_TO_SEND   <= byte_to_send_d;
            READ_ENABLE    <= read_enable_d;
            SEND_INTERRUPT <= send_interrupt_d;
            if (capture_status) status_hold <= BYTE_READ;
            if (capture_dx)     dx_hold     <= BYTE_READ;
            // Partial packets live only in the hold registers until DY completes them.
            if (publish_packet) begin
                MOUSE_STATUS <= status_hold;
                MOUSE_DX     <= dx_hold;
                MOUSE_DY     <= BYTE_READ;
            end
        end
    end

    assign MASTER_STATE = state;

endmodule
